// File: rtl/mux_sequencer.sv
// Scan sequencer for a downstream latched mux: walks the enabled channels,
// strobes the channel index, waits out the settle time, then flags acquisition.
module mux_sequencer #(
  parameter int N_INPUTS  = 3,
  parameter int SEL_WIDTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic [N_INPUTS-1:0]  chan_mask,
  input  logic [CNT_WIDTH-1:0] settle,
  input  logic [CNT_WIDTH-1:0] dwell,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 clken,
  output logic                 acq_valid,
  output logic                 acq_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE,
    SWITCH,
    SETTLE,
    ACQUIRE
  } state_t;

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic                 tail, tail_d;
  logic [SEL_WIDTH-1:0] ptr, ptr_d;

  logic [N_INPUTS-1:0]  mask_q;
  logic [CNT_WIDTH-1:0] settle_q;
  logic [CNT_WIDTH-1:0] dwell_q;
  logic                 cont_q;
  logic                 capture;

  logic [SEL_WIDTH-1:0] sel_d;
  logic                 clken_d, acq_valid_d, acq_last_d, busy_d, done_d;

  logic [CNT_WIDTH-1:0] dwell_m1;
  logic                 acq_end;
  logic                 nxt_found;
  logic [SEL_WIDTH-1:0] nxt_ptr;

  function automatic logic [SEL_WIDTH-1:0] lowest_set(input logic [N_INPUTS-1:0] m);
    logic [SEL_WIDTH-1:0] idx;
    idx = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (m[i]) idx = SEL_WIDTH'(i);
    end
    return idx;
  endfunction

  // dwell=0 is treated as a single acquire cycle, so it ends on the first one.
  assign dwell_m1 = dwell_q - CNT_WIDTH'(1);
  assign acq_end  = (dwell_q == '0) || (cnt == dwell_m1);

  // Nearest enabled channel strictly above the current pointer.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ptr   = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ptr))) begin
        nxt_found = 1'b1;
        nxt_ptr   = SEL_WIDTH'(i);
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    tail_d  = tail;
    ptr_d   = ptr;
    capture = 1'b0;
    done_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !stop && (chan_mask != '0)) begin
          capture = 1'b1;
          ptr_d   = lowest_set(chan_mask);
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        cnt_d   = '0;
        tail_d  = 1'b0;
        state_d = SETTLE;
      end
      SETTLE: begin
        // cnt runs 0..settle, then one tail cycle: settle+2 cycles in total
        // without the counter ever passing settle, so settle=max is safe.
        if (tail) begin
          cnt_d   = '0;
          state_d = ACQUIRE;
        end else if (cnt == settle_q) begin
          tail_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_WIDTH'(1);
        end
      end
      ACQUIRE: begin
        if (acq_end) begin
          if (nxt_found) begin
            ptr_d   = nxt_ptr;
            state_d = SWITCH;
          end else if (cont_q) begin
            ptr_d   = lowest_set(mask_q);
            state_d = SWITCH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d = IDLE;
      capture = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they can be registered and
  // still line up with the state they describe.
  always_comb begin
    clken_d     = (state_d == SWITCH);
    sel_d       = clken_d ? ptr_d : sel;
    acq_valid_d = (state_d == ACQUIRE);
    acq_last_d  = acq_valid_d && ((dwell_q == '0) || (cnt_d == dwell_m1));
    busy_d      = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tail      <= 1'b0;
      ptr       <= '0;
      sel       <= '0;
      clken     <= 1'b0;
      acq_valid <= 1'b0;
      acq_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      tail      <= tail_d;
      ptr       <= ptr_d;
      sel       <= sel_d;
      clken     <= clken_d;
      acq_valid <= acq_valid_d;
      acq_last  <= acq_last_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // NOTE: the captured configuration is reset too, so a scan aborted by reset
  // leaves nothing behind for the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q   <= '0;
      settle_q <= '0;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
    end else if (capture) begin
      mask_q   <= chan_mask;
      settle_q <= settle;
      dwell_q  <= dwell;
      cont_q   <= continuous;
    end
  end

endmodule

// File: tb/tb_mux_sequencer.sv
// Self-checking bench for mux_sequencer: a spec-level timeline generator feeds a
// per-cycle scoreboard, and a latched-mux model checks data on acq_valid cycles.
module tb_mux_sequencer;

  localparam int N  = 3;
  localparam int SW = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic [N-1:0]  chan_mask = '0;
  logic [CW-1:0] settle = '0;
  logic [CW-1:0] dwell = '0;
  logic [SW-1:0] sel;
  logic          clken, acq_valid, acq_last, busy, done;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic          clken;
    logic          acq_valid;
    logic          acq_last;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t          sb_q[$];
  logic [SW-1:0] exp_sel = '0;
  int            n_checks = 0;
  int            n_errors = 0;

  // Downstream latched mux: sel register on clken, then registered data out.
  logic [7:0]    din_arr[N];
  logic [SW-1:0] sel_q;
  logic [7:0]    dout;

  mux_sequencer #(.N_INPUTS(N), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .continuous(continuous),
    .chan_mask (chan_mask),
    .settle    (settle),
    .dwell     (dwell),
    .sel       (sel),
    .clken     (clken),
    .acq_valid (acq_valid),
    .acq_last  (acq_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    din_arr[0] = 8'h3c;
    din_arr[1] = 8'ha5;
    din_arr[2] = 8'h5a;
  end

  always @(posedge clk) begin
    if (clken) sel_q <= sel;
    dout <= (int'(sel_q) < N) ? din_arr[sel_q] : 8'h00;
  end

  // Scoreboard: one expected entry per cycle, compared on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      a = {sel, clken, acq_valid, acq_last, busy, done};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL scoreboard t=%0t: got sel=%0d clken=%b av=%b al=%b busy=%b done=%b, want sel=%0d clken=%b av=%b al=%b busy=%b done=%b",
                 $time, a.sel, a.clken, a.acq_valid, a.acq_last, a.busy, a.done,
                 e.sel, e.clken, e.acq_valid, e.acq_last, e.busy, e.done);
      end
      if (acq_valid === 1'b1) begin
        n_checks++;
        if (int'(sel) >= N || dout !== din_arr[sel]) begin
          n_errors++;
          $display("FAIL downstream t=%0t: sel=%0d dout=%h", $time, sel, dout);
        end
      end
    end
  end

  task automatic drain(input int limit);
    int cyc = 0;
    while (sb_q.size() != 0 && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain timeout: %0d entries left, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Expected timeline from the scan definition: per enabled channel one switch
  // cycle, settle+2 blanking cycles, max(dwell,1) acquire cycles.
  task automatic run_scan(input logic [N-1:0] m, input logic [CW-1:0] s,
                          input logic [CW-1:0] d, input logic c,
                          input int stop_at, input bit disturb);
    exp_t seq[$];
    exp_t e;
    int   busy_len;
    int   dl;
    int   stp;
    int   cyc;
    bit   finished;
    stp = (c && stop_at < 0) ? 200 : stop_at;
    dl  = (d == '0) ? 1 : int'(d);
    e = '0;
    e.sel = exp_sel;
    seq.push_back(e);
    finished = 1'b0;
    while (!finished) begin
      for (int ch = 0; ch < N; ch++) begin
        if (m[ch]) begin
          e = '0;
          e.sel = SW'(ch);
          e.busy = 1'b1;
          e.clken = 1'b1;
          seq.push_back(e);
          e.clken = 1'b0;
          for (int k = 0; k < int'(s) + 2; k++) seq.push_back(e);
          for (int k = 0; k < dl; k++) begin
            e.acq_valid = 1'b1;
            e.acq_last  = (k == dl - 1);
            seq.push_back(e);
          end
        end
      end
      if (!c) begin
        e.acq_valid = 1'b0;
        e.acq_last  = 1'b0;
        e.busy      = 1'b0;
        e.done      = 1'b1;
        seq.push_back(e);
        finished = 1'b1;
      end else if (seq.size() > stp) begin
        finished = 1'b1;
      end
    end
    if (stp >= 0 && seq.size() > stp + 1) begin
      for (int i = 0; i <= stp; i++) sb_q.push_back(seq[i]);
      e = '0;
      e.sel = seq[stp].sel;
      sb_q.push_back(e);
      busy_len = stp;
    end else begin
      foreach (seq[i]) sb_q.push_back(seq[i]);
      busy_len = seq.size() - 2;
    end
    exp_sel = sb_q[sb_q.size() - 1].sel;

    chan_mask = m; settle = s; dwell = d; continuous = c;
    start = 1'b1; stop = 1'b0;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      stop  = (cyc == stp);
      if (disturb && cyc <= busy_len) begin
        start      = 1'($urandom_range(0, 1));
        chan_mask  = N'($urandom);
        settle     = CW'($urandom);
        dwell      = CW'($urandom);
        continuous = 1'($urandom_range(0, 1));
      end else begin
        chan_mask = m; settle = s; dwell = d; continuous = c;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    drain(10);
  endtask

  task automatic run_idle(input logic [N-1:0] m, input logic st);
    exp_t e;
    e = '0;
    e.sel = exp_sel;
    for (int i = 0; i < 5; i++) sb_q.push_back(e);
    chan_mask = m; settle = '0; dwell = 4'd1; continuous = 1'b1;
    start = 1'b1; stop = st;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    drain(20);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({sel, clken, acq_valid, acq_last, busy, done} !== '0) begin
      n_errors++;
      $display("FAIL reset_values: got %b, expected all zero",
               {sel, clken, acq_valid, acq_last, busy, done});
    end
    rst = 1'b0;
    exp_sel = '0;
    // Start offered before the first edge after release.
    run_scan(3'b001, 4'd0, 4'd2, 1'b0, -1, 1'b0);
  endtask

  task automatic test_single_pass;
    run_scan(3'b101, 4'd1, 4'd4, 1'b0, -1, 1'b0);
  endtask

  task automatic test_continuous;
    run_scan(3'b011, 4'd0, 4'd1, 1'b1, 22, 1'b0);
  endtask

  task automatic test_stop;
    run_scan(3'b101, 4'd1, 4'd4, 1'b0, 6, 1'b0);
  endtask

  task automatic test_zero_values;
    run_scan(3'b111, 4'd0, 4'd0, 1'b0, -1, 1'b0);
    run_idle(3'b000, 1'b0);
    run_idle(3'b110, 1'b1);
  endtask

  task automatic test_max_settle;
    run_scan(3'b010, 4'hf, 4'hf, 1'b0, -1, 1'b0);
  endtask

  task automatic test_single_channel;
    run_scan(3'b100, 4'd0, 4'd2, 1'b1, 20, 1'b0);
  endtask

  task automatic test_ignore_while_busy;
    run_scan(3'b110, 4'd2, 4'd3, 1'b0, -1, 1'b1);
  endtask

  task automatic test_async_reset;
    chan_mask = 3'b111; settle = 4'd10; dwell = 4'd3; continuous = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy !== 1'b1 || clken !== 1'b0) begin
      n_errors++;
      $display("FAIL pre_reset_settle: busy=%b clken=%b, expected busy=1 clken=0", busy, clken);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({sel, clken, acq_valid, acq_last, busy, done} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got %b, expected all zero",
               {sel, clken, acq_valid, acq_last, busy, done});
    end
    #1 rst = 1'b0;
    exp_sel = '0;
    @(posedge clk); #1;
    run_scan(3'b011, 4'd1, 4'd2, 1'b0, -1, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_scan(3'b001, 4'd3, 4'd1, 1'b0, -1, 1'b0);
    run_scan(3'b110, 4'd0, 4'd3, 1'b0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_continuous();
    test_stop();
    test_zero_values();
    test_max_settle();
    test_single_channel();
    test_ignore_while_busy();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_sequencer.md
MUX_SEQUENCER -- requirements
Module: mux_sequencer

Interface
REQ-001 SHALL provide parameter N_INPUTS, default 3, number of mux channels.
REQ-002 SHALL provide parameter SEL_WIDTH, default 2, channel index width.
REQ-003 SHALL provide parameter CNT_WIDTH, default 16, width of the dwell and settle counters.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a scan.
REQ-007 SHALL have port stop  input  1  abort request; has priority over start.
REQ-008 SHALL have port continuous  input  1  1 = rescan forever; 0 = single pass.
REQ-009 SHALL have port chan_mask  input  N_INPUTS  bit i = 1 enables channel i.
REQ-010 SHALL have port settle  input  CNT_WIDTH  extra blanking cycles after each switch.
REQ-011 SHALL have port dwell  input  CNT_WIDTH  acquire cycles per channel.
REQ-012 SHALL have port sel  output  SEL_WIDTH  channel index for the downstream latched mux.
REQ-013 SHALL have port clken  output  1  one-cycle latch strobe for the downstream sel register.
REQ-014 SHALL have port acq_valid  output  1  high while the downstream mux output belongs to the current channel and is settled.
REQ-015 SHALL have port acq_last  output  1  high on the final acq_valid cycle of each channel.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a single pass completes.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 The FSM SHALL have exactly four states: IDLE, SWITCH, SETTLE, ACQUIRE.
REQ-020 In IDLE, start=1 with stop=0 and chan_mask!=0 SHALL capture chan_mask, settle, dwell and continuous, then go to SWITCH with the pointer at the lowest set mask bit.
REQ-021 In IDLE, start with chan_mask=0 SHALL be ignored: no state change, no done pulse.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 Changes to inputs while busy=1 SHALL have no effect until the next accepted start.
REQ-024 SWITCH SHALL last 1 cycle, drive sel=pointer and clken=1, then go to SETTLE.
REQ-025 clken SHALL be 0 in every state except SWITCH.
REQ-026 SETTLE SHALL last settle+2 cycles, where the +2 covers the downstream 2-cycle sel-to-dout latency, then go to ACQUIRE.
REQ-027 ACQUIRE SHALL hold acq_valid=1 for max(dwell,1) cycles and assert acq_last on the final cycle.
REQ-028 After ACQUIRE, the pointer SHALL advance to the next set mask bit above the current one, then go to SWITCH.
REQ-029 If no higher mask bit is set (wrap) and the captured continuous=1, the pointer SHALL wrap to the lowest set bit and go to SWITCH.
REQ-030 On wrap with captured continuous=0, the block SHALL pulse done for 1 cycle, coincident with entry to IDLE.
REQ-031 With a single enabled channel and continuous=1, the block SHALL still re-enter SWITCH each pass, so clken pulses once per pass.
REQ-032 sel SHALL hold its last value in IDLE.
REQ-033 stop=1 in any state SHALL force IDLE on the next edge, with acq_valid=0, acq_last=0, clken=0 and no done pulse.
REQ-034 Simultaneous stop and start in IDLE SHALL leave the block in IDLE.
REQ-035 Counters SHALL be CNT_WIDTH wide, compare with equality, and never wrap mid-phase; settle=2^CNT_WIDTH-1 SHALL be legal.

Reset
REQ-036 rst=1 SHALL asynchronously force IDLE, pointer=0, sel=0, clken=0, acq_valid=0, acq_last=0, busy=0 and done=0.
REQ-037 Reset asserted mid-scan SHALL discard all captured configuration.
REQ-038 After rst deasserts, the block SHALL accept start on the first following rising edge.

Verification
REQ-039 Single pass: mask=3'b101, settle=1, dwell=4, continuous=0, start at cycle 0 -> clken at cycles 1 and 9 with sel=0 then 2; acq_valid at cycles 5-8 and 13-16; acq_last at cycles 8 and 16; done at cycle 17; busy low from cycle 17.
REQ-040 Continuous wrap: mask=3'b011, settle=0, dwell=1, continuous=1 -> sel sequence 0,1,0,1...; clken every 4 cycles; done never asserted.
REQ-041 Stop mid-ACQUIRE: assert stop on the 2nd acq_valid cycle -> next cycle acq_valid=0, busy=0, done=0; sel unchanged.
REQ-042 Zero-value edge cases: dwell=0 -> exactly one acq_valid cycle per channel, with acq_last on that same cycle; start with mask=0 -> busy stays 0.
REQ-043 Async reset mid-SETTLE: pulse rst between clock edges -> all outputs reach reset values before the next edge; a start 1 cycle after release scans normally.
REQ-044 Downstream check: bench SHALL connect a latched_mux-style stage and confirm that every acq_valid=1 cycle shows dout equal to din of channel sel.
